// File: rtl/mod_inv_sel.sv
`default_nettype none
// ============================================================================
//  Module   : mod_inv_sel
//  Purpose  : Modular inverse c = a^-1 mod m by binary extended Euclid, one
//             reduction step per clock, run-time choice of SM2 prime p or
//             SM2 group order n as the modulus.
//  Revision : 1.0  initial release
// ============================================================================
module mod_inv_sel #(
  parameter int                WIDTH = 256,
  parameter logic [WIDTH-1:0]  MOD_P = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF,
  parameter logic [WIDTH-1:0]  MOD_N = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF7203DF6B21C6052B53BBF40939D54123
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [WIDTH-1:0]  in_a,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  out_c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHK  = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;     // selected modulus
  logic [WIDTH-1:0] u_q, u_d;     // also holds operand a between IDLE and CHK
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic             err_q, err_d;

  // Halve x modulo m. For odd x, (x+m)>>1 is formed as (x>>1)+(m>>1)+m[0],
  // which equals the WIDTH+1-bit sum shifted right but never exceeds m-1,
  // so it fits in WIDTH bits without a carry-out bit.
  function automatic logic [WIDTH-1:0] f_half(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] m);
    if (x[0])
      f_half = (x >> 1) + (m >> 1) + {{(WIDTH-1){1'b0}}, m[0]};
    else
      f_half = x >> 1;
  endfunction

  // (x - y) mod m for x, y in [0, m-1]; the wrap of x-y is undone by adding m
  // in the same WIDTH-bit ring, giving a result again in [0, m-1].
  function automatic logic [WIDTH-1:0] f_sub(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] d;
    d = x - y;
    if (x < y)
      d = d + m;
    f_sub = d;
  endfunction

  // State and datapath registers; reset abandons any computation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= c_zero;
      u_q     <= c_zero;
      v_q     <= c_zero;
      x1_q    <= c_zero;
      x2_q    <= c_zero;
      out_c_q <= c_zero;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      out_c_q <= out_c_d;
      err_q   <= err_d;
    end
  end

  // Next-state and Euclid step: one action per RUN cycle in priority order.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    out_c_d = out_c_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          u_d     = in_a;
          m_d     = mode ? MOD_N : MOD_P;
          state_d = CHK;
        end
      end

      CHK: begin
        if ((u_q == c_zero) || (u_q >= m_q)) begin
          err_d   = 1'b1;
          out_c_d = c_zero;
          state_d = FIN;
        end else begin
          v_d     = m_q;
          x1_d    = c_one;
          x2_d    = c_zero;
          state_d = RUN;
        end
      end

      RUN: begin
        if (u_q == c_one) begin
          out_c_d = x1_q;
          err_d   = 1'b0;
          state_d = FIN;
        end else if (v_q == c_one) begin
          out_c_d = x2_q;
          err_d   = 1'b0;
          state_d = FIN;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = f_half(x1_q, m_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = f_half(x2_q, m_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = f_sub(x1_q, x2_q, m_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = f_sub(x2_q, x1_q, m_q);
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake is decoded straight from the state register.
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FIN);
  assign err   = err_q;
  assign out_c = out_c_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_inv_sel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_inv_sel
//  Purpose  : Directed and random-operand self-checking bench for mod_inv_sel.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_inv_sel;

  localparam logic [255:0] P = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [255:0] N = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF7203DF6B21C6052B53BBF40939D54123;
  localparam logic [255:0] HALF_P = 256'h7FFFFFFF_7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_80000000_80000000_00000000;
  localparam int LAT_MAX = 4 * 256 + 4;
  localparam int WAIT_MAX = 1100;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [255:0] in_a;
  logic         busy;
  logic         done;
  logic         err;
  logic [255:0] out_c;

  int passed;
  int failed;
  int total;

  mod_inv_sel dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .in_a  (in_a),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .out_c (out_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] m);
    logic [511:0] p;
    p = {256'b0, a} * {256'b0, b};
    mulmod = 256'(p % {256'b0, m});
  endfunction

  // One complete operation with handshake timing checks.
  task automatic run_op(input logic md, input logic [255:0] a,
                        output logic [255:0] c, output logic e);
    int lat;
    mode  = md;
    in_a  = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {255'b0, busy}, 256'd1);
    lat = 1;
    while (!done && lat < WAIT_MAX) begin
      tick();
      lat++;
    end
    check("done_seen", {255'b0, done}, 256'd1);
    check("busy_in_done", {255'b0, busy}, 256'd1);
    check("latency_bound", {255'b0, (lat <= LAT_MAX)}, 256'd1);
    c = out_c;
    e = err;
    tick();
    check("done_one_cycle", {255'b0, done}, 256'd0);
    check("busy_clear", {255'b0, busy}, 256'd0);
    check("out_hold", out_c, c);
  endtask

  initial begin
    logic [255:0] c;
    logic [255:0] a;
    logic [255:0] m;
    logic [256:0] tmp;
    logic         e;
    int           n;
    int           dones;

    passed = 0;
    failed = 0;
    total  = 0;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    in_a  = '0;
    repeat (3) tick();
    check("rst_busy", {255'b0, busy}, 256'd0);
    check("rst_done", {255'b0, done}, 256'd0);
    check("rst_err", {255'b0, err}, 256'd0);
    check("rst_out", out_c, 256'd0);
    rst = 1'b0;
    tick();

    // T1: inverse of 1
    run_op(1'b0, 256'd1, c, e);
    check("t1_out", c, 256'd1);
    check("t1_err", {255'b0, e}, 256'd0);

    // T2: hand-computed boundary operands
    run_op(1'b0, 256'd2, c, e);
    check("t2_half_p", c, HALF_P);
    run_op(1'b1, N - 256'd1, c, e);
    check("t2_n_minus1", c, N - 256'd1);
    run_op(1'b0, P - 256'd1, c, e);
    check("t2_p_minus1", c, P - 256'd1);
    tmp = ({1'b0, N} + 257'd1) >> 1;
    run_op(1'b1, 256'd2, c, e);
    check("t2_half_n", c, tmp[255:0]);
    check("t2_err", {255'b0, e}, 256'd0);

    // T4: range errors and per-mode compare
    run_op(1'b0, 256'd0, c, e);
    check("t4_zero_err", {255'b0, e}, 256'd1);
    check("t4_zero_out", c, 256'd0);
    run_op(1'b1, 256'd0, c, e);
    check("t4_zero_n_err", {255'b0, e}, 256'd1);
    run_op(1'b0, P, c, e);
    check("t4_p_mode0_err", {255'b0, e}, 256'd1);
    check("t4_p_mode0_out", c, 256'd0);
    run_op(1'b1, P, c, e);
    check("t4_p_mode1_err", {255'b0, e}, 256'd1);
    run_op(1'b1, N, c, e);
    check("t4_n_mode1_err", {255'b0, e}, 256'd1);
    run_op(1'b0, N, c, e);
    check("t4_n_mode0_err", {255'b0, e}, 256'd0);
    check("t4_n_mode0_inv", mulmod(N, c, P), 256'd1);
    run_op(1'b1, {256{1'b1}}, c, e);
    check("t4_ones_err", {255'b0, e}, 256'd1);
    check("t4_ones_out", c, 256'd0);

    // T3: random operands, inverse verified by modular product
    for (int md = 0; md < 2; md++) begin
      m = (md == 1) ? N : P;
      for (int k = 0; k < 12; k++) begin
        for (int w = 0; w < 8; w++) a[32*w +: 32] = $urandom;
        a = a % m;
        if (a == 256'd0) a = 256'd1;
        run_op(md[0], a, c, e);
        check("t3_err", {255'b0, e}, 256'd0);
        check("t3_inv", mulmod(a, c, m), 256'd1);
      end
    end

    // T5: start held high with changing operand while busy
    a     = 256'd3;
    mode  = 1'b0;
    in_a  = a;
    start = 1'b1;
    tick();
    n = 0;
    dones = 0;
    while (!done && n < WAIT_MAX) begin
      in_a = a + 256'(n) + 256'd5;
      tick();
      n++;
    end
    start = 1'b0;
    if (done) dones++;
    check("t5_inv_first", mulmod(a, out_c, P), 256'd1);
    check("t5_err", {255'b0, err}, 256'd0);
    repeat (6) begin
      tick();
      if (done) dones++;
    end
    check("t5_one_done", 256'(dones), 256'd1);
    check("t5_idle", {255'b0, busy}, 256'd0);

    // T6: reset in the middle of RUN
    mode  = 1'b1;
    in_a  = 256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("t6_busy_pre", {255'b0, busy}, 256'd1);
    rst = 1'b1;
    tick();
    check("t6_busy", {255'b0, busy}, 256'd0);
    check("t6_done", {255'b0, done}, 256'd0);
    check("t6_out", out_c, 256'd0);
    check("t6_err", {255'b0, err}, 256'd0);
    rst = 1'b0;
    tick();
    run_op(1'b1, 256'd3, c, e);
    check("t6_after_err", {255'b0, e}, 256'd0);
    check("t6_after_inv", mulmod(256'd3, c, N), 256'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
